maze_ram_arbiter: RTL
=====================

Name: maze_ram_arbiter

Overview:
Controller for the 512x16 dual-port maze RAM. It owns one RAM port and shares it between two requesters: r0 is the game logic (read/write) and r1 is the display scanner (read-only). After reset, or on command, it first runs a sequencer that fills every RAM word with CLEAR_VAL. After that it arbitrates r0/r1 accesses round-robin, one access per cycle.

Parameters:
AW, 9, RAM address width
DW, 16, RAM data width
DEPTH, 512, number of words cleared (2**AW)
CLEAR_VAL, 16'h0000, fill value written by the clear sequencer

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
clear_start  in  1  one-cycle pulse; starts a full RAM fill when in RUN
busy  out  1  high while in INIT or CLEAR
r0_req  in  1  r0 access request; held until r0_gnt
r0_we  in  1  1=write, 0=read
r0_addr  in  AW  r0 address
r0_wdata  in  DW  r0 write data
r0_gnt  out  1  r0 access performed this cycle
r0_rvalid  out  1  r0 read data valid this cycle
r0_rdata  out  DW  r0 read data
r1_req  in  1  r1 read request; held until r1_gnt
r1_addr  in  AW  r1 address
r1_gnt  out  1  r1 access performed this cycle
r1_rvalid  out  1  r1 read data valid
r1_rdata  out  DW  r1 read data
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_dout  in  DW  RAM read data; valid the cycle after the address is sampled

Behaviour:
- States: INIT, CLEAR, RUN. Registers: state, clear counter cnt[AW-1:0], round-robin pointer prio, rvalid flags.
- Reset (rst_n=0 at an edge): state=INIT, cnt=0, prio=0 (r0 preferred), r0_rvalid=r1_rvalid=0.
- Reset output values: busy=1, ram_we=0, ram_addr=0, ram_din=0, gnts=0, rvalids=0, rdata=0.
- Reset mid-CLEAR or mid-RUN abandons everything. The fill restarts from address 0 after INIT.
- INIT lasts 1 cycle with no RAM access, then goes to CLEAR.
- CLEAR: ram_we=1, ram_addr=cnt, ram_din=CLEAR_VAL, and cnt increments each cycle. When the write to cnt=DEPTH-1 completes, cnt wraps to 0 and state goes to RUN.
- Fill duration is DEPTH cycles, so busy stays high for exactly 1+DEPTH cycles after reset release.
- During INIT/CLEAR, gnts are 0 and requests are not accepted. Requesters keep req high.
- clear_start is ignored in INIT/CLEAR. In RUN, clear_start moves the state to CLEAR on the next cycle with cnt=0.
- If a RUN-cycle grant coincides with clear_start, that access still completes.
- RUN arbitration is combinational in the same cycle, so gnt is high in the same cycle as the accepted req:
  - Only one req high: that requester is granted.
  - Both high: the requester selected by prio (0=r0, 1=r1) is granted.
  - After any grant, prio points to the other requester. With no grant, prio is held.
- Granted requester drives the RAM port: ram_addr is its address, ram_we=r0_we for r0 and 0 for r1, ram_din=r0_wdata.
- With no grant: ram_we=0, ram_addr=0, ram_din=0.
- Read latency is 1 cycle. A read grant at cycle t sets that requester's rvalid at t+1.
- rdata = rvalid ? ram_dout : 0. The r0 write grant produces no rvalid.
- At most one gnt per cycle and at most one rvalid per cycle.
- Addresses are used unmodified, so 0..DEPTH-1 are all valid; no address checking.

Test Plan:
- Release rst_n after 3 cycles -> busy=1 for 513 cycles; ram_we=1 with ram_addr 0..511 and ram_din=16'h0000 in order; busy=0 afterwards; an r1 read of 9'h0C3 returns 16'h0000.
- r0 write 9'h1A5/16'hBEEF, then r1 read 9'h1A5 -> r0_gnt and r1_gnt each in their request cycle; r1_rvalid=1 next cycle with r1_rdata=16'hBEEF; r0_rvalid stays 0.
- Both reqs held high in RUN after reset -> grants r0,r1,r0,r1...; each read's rvalid follows 1 cycle later with correct data.
- clear_start pulsed in the same cycle as an r0 write 9'h1FF/16'h1234 -> write granted; CLEAR for 512 cycles; held r1_req for 9'h1FF is not granted until the first RUN cycle, then returns 16'h0000.
- rst_n low for 1 cycle when cnt=200 -> all outputs take reset values; after release, the fill restarts at address 0 and busy lasts 513 cycles.
- clear_start pulsed during CLEAR at cnt=100 -> ignored; CLEAR ends at the original time (cnt=511 write, then RUN).

Source files
------------

// File: rtl/maze_ram_arbiter.sv
// Maze RAM controller: fills the RAM with CLEAR_VAL after reset or on command,
// then shares one RAM port round-robin between the game logic (r0, read/write)
// and the display scanner (r1, read-only).
module maze_ram_arbiter #(
  parameter int unsigned   AW        = 9,
  parameter int unsigned   DW        = 16,
  parameter int unsigned   DEPTH     = 512,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_start,
  output logic          busy,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_prio;
  logic          w_prio_nxt;
  logic          r_r0_rvalid;
  logic          r_r1_rvalid;
  logic          w_r0_gnt;
  logic          w_r1_gnt;
  logic          w_busy;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_din;

  // State, clear counter, round-robin pointer and read-valid flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_prio      <= 1'b0;
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_prio      <= w_prio_nxt;
      r_r0_rvalid <= w_r0_gnt & ~r0_we;
      r_r1_rvalid <= w_r1_gnt;
    end
  end

  // Next state, fill sequencing and same-cycle arbitration of the RAM port
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_prio_nxt  = r_prio;
    w_r0_gnt    = 1'b0;
    w_r1_gnt    = 1'b0;
    w_busy      = 1'b1;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_din   = '0;
    case (r_state)
      S_INIT: begin
        w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_cnt;
        w_ram_din  = CLEAR_VAL;
        if (r_cnt == LAST_ADDR) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_RUN: begin
        w_busy   = 1'b0;
        // prio=0 favours r0 on contention, prio=1 favours r1
        w_r0_gnt = r0_req & (~r1_req | ~r_prio);
        w_r1_gnt = r1_req & ~w_r0_gnt;
        if (w_r0_gnt) begin
          w_ram_we   = r0_we;
          w_ram_addr = r0_addr;
          w_ram_din  = r0_wdata;
          w_prio_nxt = 1'b1;
        end else if (w_r1_gnt) begin
          w_ram_addr = r1_addr;
          w_ram_din  = r0_wdata;
          w_prio_nxt = 1'b0;
        end
        // A grant in the same cycle still completes; the fill starts next cycle
        if (clear_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign busy      = w_busy;
  assign r0_gnt    = w_r0_gnt;
  assign r1_gnt    = w_r1_gnt;
  assign ram_we    = w_ram_we;
  assign ram_addr  = w_ram_addr;
  assign ram_din   = w_ram_din;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign r0_rdata  = r_r0_rvalid ? ram_dout : '0;
  assign r1_rdata  = r_r1_rvalid ? ram_dout : '0;

endmodule
